axerr_monitor: RTL and testbench

Streaming error-metric unit placed directly downstream of the approximate upper-part adder. It takes each operand set together with the adder's approximate sum/carry and recomputes the exact sum internally. Over a programmable window of samples it accumulates error count, summed error distance and maximum error distance. Used in characterisation builds to score an approximation configuration against exact addition.

---
 rtl/axerr_pkg.sv | 30 +++
 rtl/axerr_ed.sv | 25 ++
 rtl/axerr_monitor.sv | 174 +++++++++++++++++
 tb/tb_axerr_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axerr_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
package axerr_pkg;

  // Monitor control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Accept, error-distance and accumulate stages
  localparam int unsigned PIPE_DEPTH = 3;

  // Default geometry
  localparam int unsigned N_DEF     = 32;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ACC_W_DEF = 48;

  // An error distance spans the full exact sum, carry-out included
  function automatic int unsigned ed_width(input int unsigned n);
    return n + 1;
  endfunction

  // The accumulator must hold at least one full error distance
  function automatic bit acc_fits(input int unsigned n, input int unsigned acc_w);
    return acc_w >= ed_width(n);
  endfunction

endpackage

// File: rtl/axerr_ed.sv
// Exact-sum recompute and absolute error distance against the approximate sum.
module axerr_ed #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  input  logic [N:0]   approx,
  output logic [N:0]   ed,
  output logic         nz
);

  localparam int unsigned W = N + 1;

  logic [N:0] exact;

  // |exact - approx| without a signed intermediate
  always_comb begin
    exact = W'(a) + W'(b) + W'(c);
    if (exact >= approx) ed = exact - approx;
    else                 ed = approx - exact;
    nz = (exact != approx);
  end

endmodule

// File: rtl/axerr_monitor.sv
// Windowed error-metric monitor for the approximate upper-part adder.
module axerr_monitor
  import axerr_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic             c_i,
  input  logic [N-1:0]     s_i,
  input  logic             co_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [ACC_W-1:0] ed_sum_o,
  output logic [N:0]       ed_max_o,
  output logic             ovf_o
);

  localparam int unsigned ED_W  = ed_width(N);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned AUG_W = acc_fits(N, ACC_W) ? ACC_W : ED_W;

  state_t           state, state_n;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_n;
  logic [CNT_W-1:0] len_q, len_n;
  logic             restart;
  logic             take;

  logic             v1;
  logic [N-1:0]     a1, b1;
  logic             c1;
  logic [ED_W-1:0]  approx1;
  logic             v2;
  logic [ED_W-1:0]  ed1, ed2;
  logic             nz1, nz2;
  logic [SUM_W-1:0] sum_ext;

  // Window control: start/abort, sample acceptance, drain detection
  always_comb begin
    state_n   = state;
    acc_cnt_n = acc_cnt;
    len_n     = len_q;
    restart   = 1'b0;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          restart   = 1'b1;
          len_n     = len_i;
          acc_cnt_n = '0;
          state_n   = (len_i != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (start_i) begin
          restart   = 1'b1;
          len_n     = len_i;
          acc_cnt_n = '0;
          state_n   = (len_i != '0) ? ST_RUN : ST_DONE;
        end else if (valid_i && ready_o) begin
          take      = 1'b1;
          acc_cnt_n = acc_cnt + CNT_W'(1);
          if (acc_cnt_n == len_q) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (start_i) begin
          restart   = 1'b1;
          len_n     = len_i;
          acc_cnt_n = '0;
          state_n   = (len_i != '0) ? ST_RUN : ST_DONE;
        end else if (!v1) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, window bookkeeping and registered status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      acc_cnt <= '0;
      len_q   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      acc_cnt <= acc_cnt_n;
      len_q   <= len_n;
      ready_o <= (state_n == ST_RUN);
      busy_o  <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      done_o  <= (state_n == ST_DONE);
    end
  end

  // Stage 1: capture the accepted operand set and approximate result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1      <= 1'b0;
      a1      <= '0;
      b1      <= '0;
      c1      <= 1'b0;
      approx1 <= '0;
    end else begin
      v1 <= take;
      if (take) begin
        a1      <= a_i;
        b1      <= b_i;
        c1      <= c_i;
        approx1 <= {co_i, s_i};
      end
    end
  end

  axerr_ed #(.N(N)) u_ed (
    .a      (a1),
    .b      (b1),
    .c      (c1),
    .approx (approx1),
    .ed     (ed1),
    .nz     (nz1)
  );

  // Stage 2: register error distance; a restart discards in-flight samples
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2  <= 1'b0;
      ed2 <= '0;
      nz2 <= 1'b0;
    end else begin
      v2 <= v1 && !restart;
      if (v1) begin
        ed2 <= ed1;
        nz2 <= nz1;
      end
    end
  end

  assign sum_ext = {1'b0, ed_sum_o} + SUM_W'(AUG_W'(ed2));

  // Stage 3: accumulate window statistics with a saturating sum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
      ed_sum_o  <= '0;
      ed_max_o  <= '0;
      ovf_o     <= 1'b0;
    end else if (restart) begin
      err_cnt_o <= '0;
      ed_sum_o  <= '0;
      ed_max_o  <= '0;
      ovf_o     <= 1'b0;
    end else if (v2) begin
      err_cnt_o <= err_cnt_o + CNT_W'(nz2);
      ed_sum_o  <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      ovf_o     <= ovf_o | sum_ext[ACC_W];
      if (ed2 > ed_max_o) ed_max_o <= ed2;
    end
  end

endmodule

// File: tb/tb_axerr_monitor.sv
// Self-checking bench for axerr_monitor; a wide-accumulator and a 33-bit
// accumulator instance see identical stimulus.
module tb_axerr_monitor;

  localparam int unsigned N      = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned ACC_W2 = 33;
  localparam longint unsigned MASK33 = (64'd1 << 33) - 64'd1;
  localparam longint unsigned MAX48  = (64'd1 << 48) - 64'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic             valid_i;
  logic [N-1:0]     a_i, b_i, s_i;
  logic             c_i, co_i;

  logic             ready_o, busy_o, done_o, ovf_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [ACC_W-1:0] ed_sum_o;
  logic [N:0]       ed_max_o;

  logic              ready2, busy2, done2, ovf2;
  logic [CNT_W-1:0]  err_cnt2;
  logic [ACC_W2-1:0] ed_sum2;
  logic [N:0]        ed_max2;

  int checks = 0;
  int errors = 0;

  longint unsigned ed_q[$];
  bit              use_fixed;
  logic [31:0]     fa[8], fb[8], fs[8];
  logic            fc[8], fco[8];

  always #5 clk = ~clk;

  axerr_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .s_i(s_i), .co_i(co_i), .busy_o(busy_o), .done_o(done_o),
    .err_cnt_o(err_cnt_o), .ed_sum_o(ed_sum_o), .ed_max_o(ed_max_o), .ovf_o(ovf_o)
  );

  axerr_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W2)) u_dut33 (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready2), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .s_i(s_i), .co_i(co_i), .busy_o(busy2), .done_o(done2),
    .err_cnt_o(err_cnt2), .ed_sum_o(ed_sum2), .ed_max_o(ed_max2), .ovf_o(ovf2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
    chk({tag, ":ready"}, 64'(ready_o), 64'(rdy));
    chk({tag, ":busy"},  64'(busy_o),  64'(bsy));
    chk({tag, ":done"},  64'(done_o),  64'(dn));
    chk({tag, ":done33"}, 64'(done2),  64'(dn));
  endtask

  // Window statistics from the list of accepted error distances
  task automatic check_stats(input string tag);
    longint unsigned cnt = 0;
    longint unsigned sum = 0;
    longint unsigned mx  = 0;
    foreach (ed_q[i]) begin
      if (ed_q[i] != 0) cnt++;
      sum += ed_q[i];
      if (ed_q[i] > mx) mx = ed_q[i];
    end
    chk({tag, ":err_cnt"},   64'(err_cnt_o), cnt);
    chk({tag, ":ed_sum"},    64'(ed_sum_o),  (sum > MAX48) ? MAX48 : sum);
    chk({tag, ":ed_max"},    64'(ed_max_o),  mx);
    chk({tag, ":ovf"},       64'(ovf_o),     64'(sum > MAX48));
    chk({tag, ":err_cnt33"}, 64'(err_cnt2),  cnt);
    chk({tag, ":ed_sum33"},  64'(ed_sum2),   (sum > MASK33) ? MASK33 : sum);
    chk({tag, ":ed_max33"},  64'(ed_max2),   mx);
    chk({tag, ":ovf33"},     64'(ovf2),      64'(sum > MASK33));
  endtask

  // Drive one operand set and return its error distance
  task automatic make_sample(input int idx, output longint unsigned ed);
    longint unsigned ex, ap;
    int kind;
    if (use_fixed) begin
      a_i = fa[idx]; b_i = fb[idx]; c_i = fc[idx]; s_i = fs[idx]; co_i = fco[idx];
    end else begin
      a_i = $urandom; b_i = $urandom; c_i = 1'($urandom_range(0, 1));
      ex   = 64'(a_i) + 64'(b_i) + 64'(c_i);
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      ap = ex;
      else if (kind == 1) ap = (ex ^ 64'($urandom_range(0, 255))) & MASK33;
      else                ap = ((64'($urandom) << 1) | 64'($urandom_range(0, 1))) & MASK33;
      s_i  = ap[31:0];
      co_i = ap[32];
    end
    ex = 64'(a_i) + 64'(b_i) + 64'(c_i);
    ap = {31'd0, co_i, s_i};
    ed = (ex >= ap) ? ex - ap : ap - ex;
  endtask

  task automatic open_window(input int len, input string tag);
    start_i = 1'b1;
    len_i   = CNT_W'(len);
    valid_i = 1'b0;
    ed_q.delete();
    step();
    start_i = 1'b0;
    len_i   = CNT_W'($urandom);
    if (len == 0) begin
      chk_ctl({tag, ":len0"}, 1'b0, 1'b0, 1'b1);
      check_stats({tag, ":len0"});
      step();
      chk_ctl({tag, ":len0_after"}, 1'b0, 1'b0, 1'b0);
    end else begin
      chk_ctl({tag, ":open"}, 1'b1, 1'b1, 1'b0);
      check_stats({tag, ":cleared"});
    end
  endtask

  // mode 0: always valid, 1: random gaps, 2: valid pattern from pat (LSB first)
  task automatic feed(input int n, input int mode, input logic [31:0] pat, input string tag);
    int acc = 0;
    int cyc = 0;
    bit v;
    longint unsigned ed;
    while (acc < n && cyc < 200) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = ($urandom_range(0, 1) == 1);
      else                v = pat[cyc % 32];
      valid_i = v;
      if (v) make_sample(acc, ed);
      else begin
        a_i = $urandom; b_i = $urandom; s_i = $urandom;
      end
      chk({tag, ":ready_in_window"}, 64'(ready_o), 64'd1);
      chk({tag, ":no_done"}, 64'(done_o), 64'd0);
      step();
      if (v) begin
        ed_q.push_back(ed);
        acc++;
      end
      cyc++;
    end
    valid_i = 1'b0;
    if (acc < n) chk({tag, ":feed_timeout"}, 64'(acc), 64'(n));
  endtask

  task automatic finish_window(input string tag);
    chk_ctl({tag, ":after_last"}, 1'b0, 1'b1, 1'b0);
    valid_i = 1'b1;
    a_i = $urandom; b_i = $urandom; s_i = $urandom; c_i = 1'b1; co_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk_ctl({tag, ":e1"}, 1'b0, 1'b1, 1'b0);
    step();
    chk_ctl({tag, ":e2_done"}, 1'b0, 1'b0, 1'b1);
    check_stats({tag, ":final"});
    start_i = 1'b1;
    len_i   = CNT_W'(3);
    step();
    start_i = 1'b0;
    chk_ctl({tag, ":idle"}, 1'b0, 1'b0, 1'b0);
    check_stats({tag, ":hold"});
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0; valid_i = 1'b0;
    a_i = '0; b_i = '0; c_i = 1'b0; s_i = '0; co_i = 1'b0;
    use_fixed = 1'b1;
    step(); step();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_stats("reset");
    rst = 1'b0;
    step();
    chk_ctl("idle0", 1'b0, 1'b0, 1'b0);

    // Exact sample
    fa[0] = 32'd5; fb[0] = 32'd7; fc[0] = 1'b0; fs[0] = 32'd12; fco[0] = 1'b0;
    open_window(1, "t1"); feed(1, 0, 32'd0, "t1"); finish_window("t1");

    // Dropped lower carry
    fa[0] = 32'h0000FFFF; fb[0] = 32'd1; fc[0] = 1'b0; fs[0] = 32'd0; fco[0] = 1'b0;
    open_window(1, "t2"); feed(1, 0, 32'd0, "t2"); finish_window("t2");

    // Four back-to-back samples with distances 3, 0, 10, 1
    fa[0] = 32'd10; fb[0] = 32'd0; fc[0] = 1'b0; fs[0] = 32'd13; fco[0] = 1'b0;
    fa[1] = 32'd1;  fb[1] = 32'd1; fc[1] = 1'b0; fs[1] = 32'd2;  fco[1] = 1'b0;
    fa[2] = 32'd20; fb[2] = 32'd0; fc[2] = 1'b0; fs[2] = 32'd10; fco[2] = 1'b0;
    fa[3] = 32'd0;  fb[3] = 32'd0; fc[3] = 1'b1; fs[3] = 32'd0;  fco[3] = 1'b0;
    open_window(4, "t3"); feed(4, 0, 32'd0, "t3"); finish_window("t3");
    chk("t3:err_cnt_const", 64'(err_cnt_o), 64'd3);
    chk("t3:ed_sum_const",  64'(ed_sum_o),  64'd14);
    chk("t3:ed_max_const",  64'(ed_max_o),  64'd10);

    // Valid gaps 1,0,0,1,0,1
    use_fixed = 1'b0;
    open_window(3, "t4"); feed(3, 2, 32'b101001, "t4"); finish_window("t4");

    // Two maximal distances: saturates the 33-bit accumulator
    use_fixed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fa[i] = 32'hFFFFFFFF; fb[i] = 32'hFFFFFFFF; fc[i] = 1'b1;
      fs[i] = 32'hFFFFFFFF; fco[i] = 1'b0;
    end
    open_window(2, "t5"); feed(2, 0, 32'd0, "t5"); finish_window("t5");
    chk("t5:ed_sum33_const", 64'(ed_sum2), 64'h1_FFFF_FFFF);
    chk("t5:ovf33_const",    64'(ovf2),    64'd1);
    chk("t5:ovf48_const",    64'(ovf_o),   64'd0);

    // Zero-length window
    open_window(0, "t6a");

    // Abort after two accepts, restart with len 5
    use_fixed = 1'b0;
    open_window(4, "t6b_first"); feed(2, 0, 32'd0, "t6b_first");
    open_window(5, "t6b_second"); feed(5, 0, 32'd0, "t6b_second");
    finish_window("t6b");

    // Asynchronous reset mid-window
    open_window(4, "t6c"); feed(2, 0, 32'd0, "t6c");
    rst = 1'b1;
    #2;
    ed_q.delete();
    chk_ctl("t6c:async", 1'b0, 1'b0, 1'b0);
    check_stats("t6c:async");
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk_ctl("t6c:idle", 1'b0, 1'b0, 1'b0);
    check_stats("t6c:idle");

    // Randomised windows
    for (int w = 0; w < 8; w++) begin
      int len;
      int mode;
      len  = int'($urandom_range(1, 10));
      mode = int'($urandom_range(0, 1));
      open_window(len, "rand");
      feed(len, mode, 32'd0, "rand");
      finish_window("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
